alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 58 +++++
 rtl/alu_sequencer_op_class_decode.sv | 31 +++
 rtl/alu_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode map, opcode classification helpers and FSM state encoding
// for the ALU micro-sequencer.
package alu_seq_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD = 5'd1;
  localparam logic [OP_W-1:0] OP_SUB = 5'd2;
  localparam logic [OP_W-1:0] OP_AND = 5'd3;
  localparam logic [OP_W-1:0] OP_OR  = 5'd4;
  localparam logic [OP_W-1:0] OP_XOR = 5'd5;
  localparam logic [OP_W-1:0] OP_SHL = 5'd6;
  localparam logic [OP_W-1:0] OP_SHR = 5'd7;
  localparam logic [OP_W-1:0] OP_MUL = 5'd8;
  localparam logic [OP_W-1:0] OP_DIV = 5'd9;
  localparam logic [OP_W-1:0] OP_NEG = 5'd10;
  localparam logic [OP_W-1:0] OP_NOT = 5'd11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOADA = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRLO  = 3'd3,
    ST_WRHI  = 3'd4
  } state_t;

  // Two-operand ops: source A is staged into Y before EXEC.
  function automatic logic op_is_binary(input logic [OP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_MUL, OP_DIV: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_is_unary(input logic [OP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_NEG, OP_NOT: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op_is_binary(op) | op_is_unary(op);
  endfunction

  // Double-width result: written back through LO and HI.
  function automatic logic op_is_wide(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_sequencer_op_class_decode.sv
// Opcode classifier: legal / unary / wide (MUL-DIV) flags for one opcode.
module op_class_decode
  import alu_seq_pkg::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic [OPW-1:0] op,
  output logic           legal,
  output logic           unary,
  output logic           wide
);

  logic            hi_zero;
  logic [OP_W-1:0] op_n;

  assign op_n = OP_W'(op);

  // Opcodes wider than the table are only legal when the extra bits are zero.
  generate
    if (OPW > OP_W) begin : g_hi
      assign hi_zero = ~|op[OPW-1:OP_W];
    end else begin : g_nohi
      assign hi_zero = 1'b1;
    end
  endgenerate

  assign legal = hi_zero & op_is_legal(op_n);
  assign unary = hi_zero & op_is_unary(op_n);
  assign wide  = hi_zero & op_is_wide(op_n);

endmodule

// File: rtl/alu_sequencer.sv
// Micro-sequencer driving register-file / ALU / Y / Z / HI / LO strobes for
// one operation at a time: load A into Y, execute, write back LO (and HI).
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned OPW = 5,
  parameter int unsigned RSW = 4
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [OPW-1:0] req_op,
  input  logic [RSW-1:0] req_ra,
  input  logic [RSW-1:0] req_rb,
  input  logic [RSW-1:0] req_rc,
  input  logic           alu_ready,
  output logic [RSW-1:0] reg_sel,
  output logic           reg_out,
  output logic           reg_in,
  output logic           y_in,
  output logic           z_in,
  output logic           zlo_out,
  output logic           zhi_out,
  output logic           hi_in,
  output logic           lo_in,
  output logic [OPW-1:0] alu_op,
  output logic           busy,
  output logic           done,
  output logic           err
);

  state_t         state;
  state_t         state_nxt;
  logic [OPW-1:0] op_q;
  logic [RSW-1:0] ra_q;
  logic [RSW-1:0] rb_q;
  logic [RSW-1:0] rc_q;
  logic           wide_q;
  logic           err_q;
  logic           accept;
  logic           dec_legal;
  logic           dec_unary;
  logic           dec_wide;

  op_class_decode #(.OPW(OPW)) u_dec (
    .op    (req_op),
    .legal (dec_legal),
    .unary (dec_unary),
    .wide  (dec_wide)
  );

  assign accept = (state == ST_IDLE) && req_valid;

  // State register, request capture and the one-cycle illegal-opcode flag.
  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      rc_q   <= '0;
      wide_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= accept && !dec_legal;
      if (accept) begin
        op_q   <= req_op;
        ra_q   <= req_ra;
        rb_q   <= req_rb;
        rc_q   <= req_rc;
        wide_q <= dec_wide;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid && dec_legal) begin
          state_nxt = dec_unary ? ST_EXEC : ST_LOADA;
        end
      end
      ST_LOADA: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (alu_ready) begin
          state_nxt = ST_WRLO;
        end
      end
      ST_WRLO:  state_nxt = wide_q ? ST_WRHI : ST_IDLE;
      ST_WRHI:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; clr forces everything low in the same cycle.
  always_comb begin
    req_ready = 1'b0;
    reg_sel   = '0;
    reg_out   = 1'b0;
    reg_in    = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    zlo_out   = 1'b0;
    zhi_out   = 1'b0;
    hi_in     = 1'b0;
    lo_in     = 1'b0;
    alu_op    = '0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    if (!clr) begin
      busy = (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          req_ready = 1'b1;
          err       = err_q;
        end
        ST_LOADA: begin
          reg_sel = rb_q;
          reg_out = 1'b1;
          y_in    = 1'b1;
        end
        ST_EXEC: begin
          reg_sel = rc_q;
          reg_out = 1'b1;
          alu_op  = op_q;
          z_in    = alu_ready;
        end
        ST_WRLO: begin
          zlo_out = 1'b1;
          if (wide_q) begin
            lo_in = 1'b1;
          end else begin
            reg_sel = ra_q;
            reg_in  = 1'b1;
            done    = 1'b1;
          end
        end
        ST_WRHI: begin
          zhi_out = 1'b1;
          hi_in   = 1'b1;
          done    = 1'b1;
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: per-cycle strobe checks for binary,
// unary, MUL, illegal, clr-during-stall and back-to-back sequences.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int unsigned OPW = 5;
  localparam int unsigned RSW = 4;

  logic           clk = 1'b0;
  logic           clr;
  logic           req_valid;
  logic           req_ready;
  logic [OPW-1:0] req_op;
  logic [RSW-1:0] req_ra;
  logic [RSW-1:0] req_rb;
  logic [RSW-1:0] req_rc;
  logic           alu_ready;
  logic [RSW-1:0] reg_sel;
  logic           reg_out;
  logic           reg_in;
  logic           y_in;
  logic           z_in;
  logic           zlo_out;
  logic           zhi_out;
  logic           hi_in;
  logic           lo_in;
  logic [OPW-1:0] alu_op;
  logic           busy;
  logic           done;
  logic           err;

  int n_total = 0;
  int n_bad   = 0;
  int bus_viol = 0;

  logic [20:0] all_out;
  logic [8:0]  strobes;

  assign all_out = {reg_sel, reg_out, reg_in, y_in, z_in, zlo_out, zhi_out,
                    hi_in, lo_in, alu_op, busy, done, err, req_ready};
  assign strobes = {reg_out, reg_in, y_in, z_in, zlo_out, zhi_out, hi_in, lo_in, done};

  alu_sequencer #(.OPW(OPW), .RSW(RSW)) dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_ra    (req_ra),
    .req_rb    (req_rb),
    .req_rc    (req_rc),
    .alu_ready (alu_ready),
    .reg_sel   (reg_sel),
    .reg_out   (reg_out),
    .reg_in    (reg_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .zlo_out   (zlo_out),
    .zhi_out   (zhi_out),
    .hi_in     (hi_in),
    .lo_in     (lo_in),
    .alu_op    (alu_op),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((32'(reg_out) + 32'(zlo_out) + 32'(zhi_out)) > 32'd1) bus_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle binary op with alu_ready high; called right after adv().
  task automatic run_binary(input logic [OPW-1:0] op, input logic [RSW-1:0] ra,
                            input logic [RSW-1:0] rb, input logic [RSW-1:0] rc);
    req_valid = 1'b1;
    req_op = op; req_ra = ra; req_rb = rb; req_rc = rc;
    #1 check("bin_accept_ready", 32'(req_ready), 32'd1);
    adv();
    req_valid = 1'b0;
    #1 check("bin_loada", 32'({reg_sel, reg_out, y_in, z_in}), 32'({rb, 1'b1, 1'b1, 1'b0}));
    adv();
    #1 check("bin_exec", 32'({reg_sel, reg_out, z_in, alu_op, y_in}),
             32'({rc, 1'b1, 1'b1, op, 1'b0}));
    adv();
    #1 check("bin_wrlo", 32'({reg_sel, reg_in, done, zlo_out, reg_out}),
             32'({ra, 1'b1, 1'b1, 1'b1, 1'b0}));
    adv();
    #1 check("bin_ready_again", 32'({req_ready, done, busy}), 32'b100);
  endtask

  initial begin
    int t_done, y_cnt, z_cnt, t_z, t_lo, t_hi, regin_cnt;

    clr = 1'b1; req_valid = 1'b0; req_op = '0;
    req_ra = '0; req_rb = '0; req_rc = '0; alu_ready = 1'b1;

    // Reset
    adv(); adv();
    #1 check("reset_outputs", 32'(all_out), 32'd0);
    adv();
    clr = 1'b0;
    #1 check("reset_release", 32'({req_ready, busy, done, err}), 32'b1000);
    adv();

    // OR ra=3 rb=1 rc=2
    run_binary(OP_OR, 4'd3, 4'd1, 4'd2);

    // Register aliasing
    run_binary(OP_SUB, 4'd4, 4'd4, 4'd4);

    // NOT: unary, no Y load, done two cycles after acceptance
    req_valid = 1'b1; req_op = OP_NOT; req_ra = 4'd5; req_rb = 4'd0; req_rc = 4'd6;
    t_done = -1; y_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) req_valid = 1'b0;
      #1;
      if (y_in) y_cnt++;
      if (k == 1) check("not_exec_sel", 32'({reg_sel, alu_op}), 32'({4'd6, OP_NOT}));
      if (done && t_done < 0) begin
        t_done = k;
        check("not_wr", 32'({reg_sel, reg_in, zlo_out}), 32'({4'd5, 1'b1, 1'b1}));
      end
      adv();
    end
    check("not_done_lat", 32'(t_done), 32'd2);
    check("not_no_y", 32'(y_cnt), 32'd0);

    // MUL: 31 stalled EXEC cycles, then result
    req_valid = 1'b1; req_op = OP_MUL; req_ra = 4'd7; req_rb = 4'd8; req_rc = 4'd9;
    alu_ready = 1'b0;
    z_cnt = 0; t_z = -1; t_lo = -1; t_hi = -1; t_done = -1; regin_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 1) req_valid = 1'b0;
      alu_ready = (k >= 33);
      #1;
      if (z_in) begin z_cnt++; t_z = k; end
      if (lo_in && t_lo < 0) t_lo = k;
      if (hi_in && t_hi < 0) t_hi = k;
      if (done && t_done < 0) t_done = k;
      if (reg_in) regin_cnt++;
      adv();
    end
    check("mul_z_count", 32'(z_cnt), 32'd1);
    check("mul_z_cycle", 32'(t_z), 32'd33);
    check("mul_lo_cycle", 32'(t_lo), 32'd34);
    check("mul_hi_cycle", 32'(t_hi), 32'd35);
    check("mul_done_cycle", 32'(t_done), 32'd35);
    check("mul_no_reg_in", 32'(regin_cnt), 32'd0);
    alu_ready = 1'b1;

    // Illegal opcode
    req_valid = 1'b1; req_op = 5'b11111;
    #1 check("ill_accept_ready", 32'(req_ready), 32'd1);
    adv();
    req_valid = 1'b0;
    #1 check("ill_err", 32'({err, busy, req_ready}), 32'b101);
    check("ill_no_strobes", 32'(strobes), 32'd0);
    adv();
    #1 check("ill_after", 32'({err, req_ready}), 32'b01);
    adv();

    // clr during EXEC stall, then a normal ADD
    req_valid = 1'b1; req_op = OP_ADD; req_ra = 4'd1; req_rb = 4'd2; req_rc = 4'd3;
    alu_ready = 1'b0;
    adv();
    req_valid = 1'b0;
    adv(); adv();
    #1 check("stall_exec", 32'({busy, reg_out, z_in, alu_op}), 32'({3'b110, OP_ADD}));
    adv();
    clr = 1'b1;
    #1 check("clr_outputs", 32'(all_out), 32'd0);
    adv();
    clr = 1'b0;
    #1 check("clr_release", 32'({req_ready, busy, done}), 32'b100);
    adv();
    #1 check("clr_no_done", 32'({done, busy}), 32'b00);
    alu_ready = 1'b1;
    run_binary(OP_ADD, 4'd2, 4'd4, 4'd6);
    adv();

    // Back-to-back with req_valid held; req_rb changes while busy
    req_valid = 1'b1; req_op = OP_ADD; req_ra = 4'd1; req_rb = 4'd1; req_rc = 4'd2;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) req_rb = 4'd7;
      #1;
      if (k == 1) check("b2b_loada1", 32'({reg_sel, y_in}), 32'({4'd1, 1'b1}));
      if (k == 3) check("b2b_done1", 32'(done), 32'd1);
      if (k == 4) check("b2b_accept2", 32'({req_ready, busy}), 32'b10);
      if (k == 5) check("b2b_loada2", 32'({reg_sel, y_in}), 32'({4'd7, 1'b1}));
      if (k == 7) check("b2b_done2", 32'({done, reg_sel}), 32'({1'b1, 4'd1}));
      adv();
    end
    req_valid = 1'b0;
    adv(); adv(); adv(); adv();
    #1 check("b2b_idle", 32'({req_ready, busy}), 32'b10);

    check("bus_exclusive", 32'(bus_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
